phj_release_sequencer: RTL and testbench

Central release controller for the partitioned-hash-join output stage. It hands out serial numbers to the upstream join pipeline, limited by the reorder window. It broadcasts the `next` serial to all store-and-release lanes and grants exactly one lane per cycle the right to release or drop the tuple for `next`. It merges lane outputs into a single in-order, back-pressured stream and raises a global end-of-stream flag once every lane has drained.

---
 rtl/phj_release_pkg.sv | 19 +
 rtl/phj_release_fifo.sv | 51 +++++
 rtl/phj_release_sequencer.sv | 163 ++++++++++++++++
 tb/tb_phj_release_sequencer.sv | 383 ++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/phj_release_pkg.sv
// Shared types and helpers for the partitioned-hash-join release sequencer.
package phj_release_pkg;

    localparam int MAX_LANES = 32;

    typedef logic [31:0] serial_t;

    typedef enum logic [1:0] {
        RUN   = 2'd0,
        DRAIN = 2'd1,
        DONE  = 2'd2
    } relseq_state_e;

    // Isolates the lowest set bit (priority select by lowest index).
    function automatic logic [MAX_LANES-1:0] lowest_onehot(input logic [MAX_LANES-1:0] v);
        return v & (~v + MAX_LANES'(1));
    endfunction

endpackage

// File: rtl/phj_release_fifo.sv
// Synchronous skid FIFO for the merged release stream; head reads as zero when empty.
module phj_release_fifo #(
    parameter int DATA_SIZE  = 128,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                          clk,
    input  logic                          resetn,
    input  logic                          i_push,
    input  logic [DATA_SIZE-1:0]          i_data,
    input  logic                          i_pop,
    output logic [DATA_SIZE-1:0]          o_data,
    output logic                          o_empty,
    output logic [$clog2(FIFO_DEPTH):0]   o_count
);

    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int CW = AW + 1;

    logic [DATA_SIZE-1:0] r_mem [FIFO_DEPTH];
    logic [AW-1:0]        r_wr;
    logic [AW-1:0]        r_rd;
    logic [CW-1:0]        r_count;
    logic                 w_full;
    logic                 w_pop;
    logic                 w_push;

    assign o_empty = (r_count == '0);
    assign w_full  = (r_count == CW'(FIFO_DEPTH));
    assign w_pop   = i_pop & ~o_empty;
    // A full FIFO still accepts a push when the head leaves in the same cycle.
    assign w_push  = i_push & (~w_full | w_pop);
    assign o_data  = o_empty ? '0 : r_mem[r_rd];
    assign o_count = r_count;

    always_ff @(posedge clk) begin
        if (w_push) r_mem[r_wr] <= i_data;
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            r_wr    <= '0;
            r_rd    <= '0;
            r_count <= '0;
        end else begin
            if (w_push) r_wr <= r_wr + AW'(1);
            if (w_pop)  r_rd <= r_rd + AW'(1);
            r_count <= r_count + CW'(w_push) - CW'(w_pop);
        end
    end

endmodule

// File: rtl/phj_release_sequencer.sv
// Central in-order release controller for the PHJ output stage.
// Optional stat_released/stat_skipped counters are built when PHJ_RELSEQ_STATS_EN is defined.
module phj_release_sequencer
    import phj_release_pkg::*;
#(
    parameter int NUM_LANES  = 4,
    parameter int DATA_SIZE  = 128,
    parameter int MAX_NUM    = 2,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                           clk,
    input  logic                           resetn,
    output logic                           issue_ready,
    input  logic                           issue_valid,
    output serial_t                        issue_serial,
    input  logic                           src_done,
    output serial_t                        next,
    input  logic [NUM_LANES-1:0]           lane_next_in_storage,
    input  logic [NUM_LANES-1:0]           lane_next_joined,
    output logic [NUM_LANES-1:0]           lane_release,
    output logic [NUM_LANES-1:0]           lane_skip,
    input  logic [NUM_LANES-1:0]           lane_out_valid,
    input  logic [NUM_LANES*DATA_SIZE-1:0] lane_out_data,
    input  logic [NUM_LANES-1:0]           lane_local_last,
    output logic                           lane_last_processed,
    output logic                           out_valid,
    output logic [DATA_SIZE-1:0]           out_data,
    input  logic                           out_ready,
    output logic                           all_last_processed,
    output logic                           err_conflict,
    output logic [1:0]                     dbg_state
`ifdef PHJ_RELSEQ_STATS_EN
    ,
    output logic [31:0]                    stat_released,
    output logic [31:0]                    stat_skipped
`endif
);

    relseq_state_e               r_state;
    relseq_state_e               w_state_nxt;
    serial_t                     r_issue_serial;
    serial_t                     r_next;
    logic                        r_inflight;
    logic                        r_err;

    serial_t                     w_occ;
    logic                        w_issue_fire;
    logic                        w_hit;
    logic [NUM_LANES-1:0]        w_sel;
    logic                        w_sel_joined;
    logic                        w_multi;
    logic                        w_room;
    logic                        w_release;
    logic                        w_skip;
    logic                        w_stray;
    logic [DATA_SIZE-1:0]        w_merged;
    logic                        w_fifo_empty;
    logic [$clog2(FIFO_DEPTH):0] w_fifo_count;

    // Modular distance keeps the window check correct across serial wrap.
    assign w_occ        = r_issue_serial - r_next;
    assign w_issue_fire = issue_valid & issue_ready;

    assign w_hit        = (w_occ != '0) & (|lane_next_in_storage);
    assign w_sel        = NUM_LANES'(lowest_onehot(MAX_LANES'(lane_next_in_storage)));
    assign w_sel_joined = |(w_sel & lane_next_joined);
    assign w_multi      = |(lane_next_in_storage & (lane_next_in_storage - NUM_LANES'(1)));

    // Reserve a FIFO slot for every tuple already promised, including this one.
    assign w_room    = (32'(w_fifo_count) + 32'(r_inflight)) < 32'(FIFO_DEPTH);
    assign w_release = w_hit & w_sel_joined & w_room;
    assign w_skip    = w_hit & ~w_sel_joined;

    assign lane_release = {NUM_LANES{w_release}} & w_sel;
    assign lane_skip    = {NUM_LANES{w_skip}} & w_sel;

    assign w_stray = (|lane_out_valid) & ~r_inflight;

    always_comb begin
        w_merged = '0;
        for (int i = 0; i < NUM_LANES; i++) begin
            if (lane_out_valid[i]) w_merged = w_merged | lane_out_data[i*DATA_SIZE +: DATA_SIZE];
        end
    end

    always_comb begin
        w_state_nxt         = r_state;
        issue_ready         = 1'b0;
        lane_last_processed = 1'b0;
        all_last_processed  = 1'b0;
        case (r_state)
            RUN: begin
                issue_ready = (w_occ < serial_t'(MAX_NUM));
                if (src_done) w_state_nxt = DRAIN;
            end
            DRAIN: begin
                lane_last_processed = 1'b1;
                if ((w_occ == '0) && !r_inflight && w_fifo_empty && (&lane_local_last))
                    w_state_nxt = DONE;
            end
            DONE: begin
                lane_last_processed = 1'b1;
                all_last_processed  = 1'b1;
            end
            default: w_state_nxt = RUN;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            r_state        <= RUN;
            r_issue_serial <= '0;
            r_next         <= '0;
            r_inflight     <= 1'b0;
            r_err          <= 1'b0;
        end else begin
            r_state        <= w_state_nxt;
            r_issue_serial <= r_issue_serial + serial_t'(w_issue_fire);
            r_next         <= r_next + serial_t'(w_release | w_skip);
            r_inflight     <= w_release;
            r_err          <= r_err | (w_hit & w_multi) | w_stray;
        end
    end

    phj_release_fifo #(
        .DATA_SIZE  (DATA_SIZE),
        .FIFO_DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk     (clk),
        .resetn  (resetn),
        .i_push  (r_inflight),
        .i_data  (w_merged),
        .i_pop   (out_ready),
        .o_data  (out_data),
        .o_empty (w_fifo_empty),
        .o_count (w_fifo_count)
    );

    assign out_valid    = ~w_fifo_empty;
    assign issue_serial = r_issue_serial;
    assign next         = r_next;
    assign err_conflict = r_err;
    assign dbg_state    = r_state;

`ifdef PHJ_RELSEQ_STATS_EN
    serial_t r_stat_rel;
    serial_t r_stat_skp;

    always_ff @(posedge clk) begin
        if (!resetn) begin
            r_stat_rel <= '0;
            r_stat_skp <= '0;
        end else begin
            if (w_release) r_stat_rel <= r_stat_rel + 32'd1;
            if (w_skip)    r_stat_skp <= r_stat_skp + 32'd1;
        end
    end

    assign stat_released = r_stat_rel;
    assign stat_skipped  = r_stat_skp;
`endif

endmodule

// File: tb/tb_phj_release_sequencer.sv
// Self-checking bench: grant table, directed multi-cycle sequences, randomized runs vs a lane/stream model.
module tb_phj_release_sequencer;

    localparam int NL   = 4;
    localparam int DW   = 128;
    localparam int MN   = 2;
    localparam int FD   = 4;
    localparam int MAXS = 64;

    logic              clk = 1'b0;
    logic              resetn = 1'b0;
    logic              issue_ready;
    logic              issue_valid = 1'b0;
    logic [31:0]       issue_serial;
    logic              src_done = 1'b0;
    logic [31:0]       dut_next;
    logic [NL-1:0]     lane_next_in_storage = '0;
    logic [NL-1:0]     lane_next_joined = '0;
    logic [NL-1:0]     lane_release;
    logic [NL-1:0]     lane_skip;
    logic [NL-1:0]     lane_out_valid = '0;
    logic [NL*DW-1:0]  lane_out_data = '0;
    logic [NL-1:0]     lane_local_last = '0;
    logic              lane_last_processed;
    logic              out_valid;
    logic [DW-1:0]     out_data;
    logic              out_ready = 1'b0;
    logic              all_last_processed;
    logic              err_conflict;
    logic [1:0]        dbg_state;
`ifdef PHJ_RELSEQ_STATS_EN
    logic [31:0]       stat_released;
    logic [31:0]       stat_skipped;
`endif

    always #5 clk = ~clk;

    phj_release_sequencer #(
        .NUM_LANES(NL), .DATA_SIZE(DW), .MAX_NUM(MN), .FIFO_DEPTH(FD)
    ) dut (
        .clk(clk), .resetn(resetn),
        .issue_ready(issue_ready), .issue_valid(issue_valid), .issue_serial(issue_serial),
        .src_done(src_done), .next(dut_next),
        .lane_next_in_storage(lane_next_in_storage), .lane_next_joined(lane_next_joined),
        .lane_release(lane_release), .lane_skip(lane_skip),
        .lane_out_valid(lane_out_valid), .lane_out_data(lane_out_data),
        .lane_local_last(lane_local_last), .lane_last_processed(lane_last_processed),
        .out_valid(out_valid), .out_data(out_data), .out_ready(out_ready),
        .all_last_processed(all_last_processed), .err_conflict(err_conflict),
        .dbg_state(dbg_state)
`ifdef PHJ_RELSEQ_STATS_EN
        , .stat_released(stat_released), .stat_skipped(stat_skipped)
`endif
    );

    int n_cmp = 0;
    int n_fail = 0;

    task automatic chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: actual=%0h required=%0h", name, act, exp);
        end
    endtask

    task automatic flag_fail(input string name, input string why);
        n_cmp++;
        n_fail++;
        $display("FAIL %s: %s", name, why);
    endtask

    // Lane/stream model: each planned serial lives in one lane, joined or not.
    int            n_ser, n_issued, exp_next, cyc, rel_cnt, skp_cnt, ov_cnt, nr_cnt;
    int            s_lane [MAXS];
    bit            s_join [MAXS];
    logic [DW-1:0] s_data [MAXS];
    int            s_delay [MAXS];
    int            s_arr_at [MAXS];
    bit            s_iss [MAXS];
    bit            s_gone [MAXS];
    int            first_rel [NL];
    int            skp_lane [NL];
    logic [NL-1:0] mask;
    bit            done_seen, rand_ready, dup_en;
    logic [DW-1:0] exp_q [$];

    task automatic do_reset();
        resetn = 1'b0;
        issue_valid = 1'b0;
        src_done = 1'b0;
        lane_next_in_storage = '0;
        lane_next_joined = '0;
        lane_out_valid = '0;
        lane_out_data = '0;
        lane_local_last = '0;
        out_ready = 1'b0;
        n_ser = 0; n_issued = 0; exp_next = 0; cyc = 0;
        rel_cnt = 0; skp_cnt = 0; ov_cnt = 0; nr_cnt = 0;
        mask = '0; done_seen = 0; rand_ready = 0; dup_en = 0;
        exp_q.delete();
        for (int i = 0; i < MAXS; i++) begin
            s_iss[i] = 0; s_gone[i] = 0; s_arr_at[i] = 0; s_delay[i] = 0;
        end
        for (int i = 0; i < NL; i++) begin
            first_rel[i] = -1; skp_lane[i] = 0;
        end
        repeat (2) @(posedge clk);
        #1;
        resetn = 1'b1;
    endtask

    task automatic add_ser(input int lane, input bit joined, input int delay);
        s_lane[n_ser]  = lane;
        s_join[n_ser]  = joined;
        s_delay[n_ser] = delay;
        s_data[n_ser]  = {$urandom(), $urandom(), $urandom(), $urandom()};
        if (joined) exp_q.push_back(s_data[n_ser]);
        n_ser++;
    endtask

    task automatic update_lanes();
        int nx;
        nx = int'(dut_next);
        lane_next_in_storage = '0;
        lane_next_joined = '0;
        if (nx >= 0 && nx < n_ser && s_iss[nx] && !s_gone[nx] && cyc >= s_arr_at[nx]
            && !mask[s_lane[nx]]) begin
            lane_next_in_storage[s_lane[nx]] = 1'b1;
            lane_next_joined[s_lane[nx]] = s_join[nx];
            if (dup_en && s_lane[nx] == 0) begin
                lane_next_in_storage[1] = 1'b1;
                lane_next_joined[1] = 1'b1;
            end
        end
        for (int i = 0; i < NL; i++) begin
            lane_local_last[i] = (n_issued == n_ser);
            for (int k = 0; k < n_ser; k++)
                if (s_lane[k] == i && s_iss[k] && !s_gone[k]) lane_local_last[i] = 1'b0;
        end
        issue_valid = (n_issued < n_ser);
        if (rand_ready) out_ready = 1'($urandom_range(0, 1));
    endtask

    task automatic tick();
        logic [NL-1:0] rel, skp, erel, eskp;
        bit exp_rdy;
        int rs;
        @(negedge clk);
        rel = lane_release;
        skp = lane_skip;
        rs = -1;
        exp_rdy = !done_seen && ((n_issued - exp_next) < MN);
        chk("issue_ready", issue_ready, exp_rdy);
        if (!issue_ready) nr_cnt++;
        if (issue_valid && issue_ready) begin
            chk("issue_serial", issue_serial, n_issued);
            if (n_issued < MAXS) begin
                s_iss[n_issued] = 1;
                s_arr_at[n_issued] = cyc + 1 + s_delay[n_issued];
            end
            n_issued++;
        end
        if (out_valid) begin
            ov_cnt++;
            if (out_ready) begin
                if (exp_q.size() == 0) flag_fail("out_extra", "output with nothing expected");
                else chk("out_data", out_data, exp_q.pop_front());
            end
        end
        if ((rel | skp) != '0) begin
            chk("grant_next", dut_next, exp_next);
            if (exp_next < n_ser) begin
                erel = '0; eskp = '0;
                if (s_join[exp_next]) erel[s_lane[exp_next]] = 1'b1;
                else eskp[s_lane[exp_next]] = 1'b1;
                chk("grant_release", rel, erel);
                chk("grant_skip", skp, eskp);
                s_gone[exp_next] = 1;
                rs = exp_next;
            end else begin
                flag_fail("grant_extra", "grant beyond planned serials");
            end
            exp_next++;
            rel_cnt += $countones(rel);
            skp_cnt += $countones(skp);
            for (int i = 0; i < NL; i++) begin
                if (rel[i] && first_rel[i] < 0) first_rel[i] = cyc;
                if (skp[i]) skp_lane[i]++;
            end
        end
        @(posedge clk);
        #1;
        cyc++;
        if (src_done) done_seen = 1;
        lane_out_valid = '0;
        lane_out_data = '0;
        mask = '0;
        for (int i = 0; i < NL; i++) begin
            if (rel[i] && rs >= 0) begin
                lane_out_valid[i] = 1'b1;
                lane_out_data[i*DW +: DW] = s_data[rs];
                mask[i] = 1'b1;
            end
        end
        update_lanes();
    endtask

    task automatic run_until(input int budget, input string name);
        int k;
        k = 0;
        while (!(n_issued == n_ser && exp_next == n_ser && exp_q.size() == 0) && k < budget) begin
            tick();
            k++;
        end
        if (!(n_issued == n_ser && exp_next == n_ser && exp_q.size() == 0))
            flag_fail(name, "cycle budget expired");
    endtask

    task automatic finish_run(input string name);
        int k;
        src_done = 1'b1;
        k = 0;
        while (!all_last_processed && k < 20) begin
            tick();
            k++;
        end
        if (!all_last_processed) flag_fail(name, "DONE not reached");
        chk("lane_last_processed", lane_last_processed, 1'b1);
    endtask

    typedef struct {
        logic [NL-1:0] claim;
        logic [NL-1:0] joined;
        logic [NL-1:0] e_rel;
        logic [NL-1:0] e_skp;
    } vec_t;

    vec_t vt [8];

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int n, nj;
        bit j;

        vt[0] = '{4'b0000, 4'b0000, 4'b0000, 4'b0000};
        vt[1] = '{4'b0001, 4'b0001, 4'b0001, 4'b0000};
        vt[2] = '{4'b0100, 4'b0000, 4'b0000, 4'b0100};
        vt[3] = '{4'b0110, 4'b0010, 4'b0010, 4'b0000};
        vt[4] = '{4'b0110, 4'b0100, 4'b0000, 4'b0010};
        vt[5] = '{4'b1000, 4'b1000, 4'b1000, 4'b0000};
        vt[6] = '{4'b1100, 4'b0111, 4'b0100, 4'b0000};
        vt[7] = '{4'b0011, 4'b0010, 4'b0000, 4'b0001};

        // Reset state
        do_reset();
        update_lanes();
        chk("rst_next", dut_next, 0);
        chk("rst_issue_serial", issue_serial, 0);
        chk("rst_issue_ready", issue_ready, 1'b1);
        chk("rst_out_valid", out_valid, 1'b0);
        chk("rst_out_data", out_data, '0);
        chk("rst_all_last", all_last_processed, 1'b0);
        chk("rst_lane_last", lane_last_processed, 1'b0);
        chk("rst_err", err_conflict, 1'b0);
        chk("rst_state", dbg_state, 2'd0);

        // Grant table with two serials outstanding; claims withdrawn before each edge
        issue_valid = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        issue_valid = 1'b0;
        chk("window_full_ready", issue_ready, 1'b0);
        chk("window_full_serial", issue_serial, 2);
        for (int v = 0; v < 8; v++) begin
            @(negedge clk);
            #1;
            lane_next_in_storage = vt[v].claim;
            lane_next_joined = vt[v].joined;
            #1;
            chk($sformatf("tbl%0d_release", v), lane_release, vt[v].e_rel);
            chk($sformatf("tbl%0d_skip", v), lane_skip, vt[v].e_skp);
            lane_next_in_storage = '0;
            lane_next_joined = '0;
        end

        // In-order release: serial 1 ready in lane 2 well before serial 0 in lane 0
        do_reset();
        add_ser(0, 1, 4);
        add_ser(2, 1, 0);
        out_ready = 1'b1;
        update_lanes();
        run_until(200, "inorder_timeout");
        chk("inorder_lane0_first", (first_rel[0] >= 0) && (first_rel[0] < first_rel[2]), 1'b1);
        chk("inorder_next", dut_next, 2);

        // Skip: non-joined serial in lane 1
        do_reset();
        add_ser(1, 0, 0);
        out_ready = 1'b1;
        update_lanes();
        run_until(100, "skip_timeout");
        chk("skip_lane1_cycles", skp_lane[1], 1);
        chk("skip_next", dut_next, 1);
        chk("skip_no_output", ov_cnt, 0);
        chk("skip_no_release", rel_cnt, 0);

        // Window full: serial 0 arrives late, blocking further issues
        do_reset();
        add_ser(0, 0, 6);
        add_ser(1, 1, 0);
        add_ser(2, 1, 0);
        out_ready = 1'b1;
        update_lanes();
        run_until(200, "window_timeout");
        chk("window_blocked_cycles", nr_cnt >= 5, 1'b1);

        // Backpressure: six joined serials, output stalled
        do_reset();
        for (int i = 0; i < 6; i++) add_ser(i % NL, 1, 0);
        out_ready = 1'b0;
        update_lanes();
        repeat (30) tick();
        chk("bp_releases", rel_cnt, 4);
        chk("bp_next", dut_next, 4);
        chk("bp_out_valid", out_valid, 1'b1);
        chk("bp_head_held", out_data, exp_q[0]);
        out_ready = 1'b1;
        run_until(300, "bp_timeout");
        chk("bp_all_released", rel_cnt, 6);

        // Done: src_done pulse with nothing outstanding
        do_reset();
        update_lanes();
        src_done = 1'b1;
        tick();
        src_done = 1'b0;
        tick();
        chk("done_state", dbg_state, 2'd2);
        chk("done_all_last", all_last_processed, 1'b1);
        chk("done_lane_last", lane_last_processed, 1'b1);

        // Conflict: lanes 0 and 1 both claim next
        do_reset();
        add_ser(0, 1, 0);
        dup_en = 1;
        out_ready = 1'b1;
        update_lanes();
        run_until(100, "conflict_timeout");
        chk("conflict_err", err_conflict, 1'b1);
        chk("conflict_lane0_granted", first_rel[0] >= 0, 1'b1);
        chk("conflict_lane1_idle", first_rel[1], -1);

        // Randomized runs against the lane/stream model
        for (int r = 0; r < 6; r++) begin
            do_reset();
            rand_ready = 1;
            n = $urandom_range(8, 24);
            nj = 0;
            for (int k = 0; k < n; k++) begin
                j = ($urandom_range(0, 3) != 0);
                add_ser($urandom_range(0, NL - 1), j, $urandom_range(0, 3));
                if (j) nj++;
            end
            update_lanes();
            run_until(2000, "rand_timeout");
            finish_run("rand_done");
            chk("rand_released", rel_cnt, nj);
            chk("rand_skipped", skp_cnt, n - nj);
            chk("rand_next", dut_next, n);
            chk("rand_err", err_conflict, 1'b0);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
